// File: rtl/even_chk_pkg.sv
// Shared constants, state encoding and the expected-next helper for the even counter checker.
// EVEN_CHK_STICKY_ERR_EN adds the FAIL state (errors in LOCKED latch until reset).
package even_chk_pkg;

  localparam int unsigned STEP    = 2;
  localparam int unsigned MOD     = 16;
  localparam logic [3:0]  WRAP_PT = 4'd14;

`ifdef EVEN_CHK_STICKY_ERR_EN
  typedef enum logic [1:0] {ST_SYNC, ST_ACQ, ST_LOCKED, ST_FAIL} state_t;
`else
  typedef enum logic [1:0] {ST_SYNC, ST_ACQ, ST_LOCKED} state_t;
`endif

  function automatic logic [3:0] next_exp(input logic [3:0] p);
    return 4'((32'(p) + STEP) % MOD);
  endfunction

endpackage

// File: rtl/even_chk_predict.sv
// Holds the last accepted sample P and flags whether the current sample is the expected successor.
module even_chk_predict
  import even_chk_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] s,
  output logic [3:0] p,
  output logic [3:0] e,
  output logic       match,
  output logic       odd
);

  always_ff @(posedge clk) begin
    if (rst)       p <= 4'd0;
    else if (load) p <= s;
  end

  assign e     = next_exp(p);
  assign match = (s == e);
  assign odd   = s[0];

endmodule

// File: rtl/even_count_checker.sv
// Sequence checker for a 4-bit +2 counter: acquires, locks, flags step errors and wraps.
// EVEN_CHK_STICKY_ERR_EN: an error in LOCKED parks the FSM in FAIL until reset.
module even_count_checker
  import even_chk_pkg::*;
#(
  parameter int unsigned LOCK_CNT  = 2,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 EN,
  input  logic                 A,
  input  logic                 B,
  input  logic                 C,
  input  logic                 D,
  output logic                 LOCK,
  output logic                 ERR,
  output logic                 WRAP,
  output logic [ERR_CNT_W-1:0] ERR_CNT
);

  localparam logic [3:0]           LOCK_CNT4 = LOCK_CNT[3:0];
  localparam logic [ERR_CNT_W-1:0] CNT_ONE   = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

  state_t     state_q, state_d;
  logic [3:0] step_q, step_d;
  logic [3:0] s, p, e;
  logic       load, match, odd, err_d, wrap_d;

  assign s = {A, B, C, D};

  even_chk_predict u_pred (
    .clk   (CLK),
    .rst   (RST),
    .load  (load),
    .s     (s),
    .p     (p),
    .e     (e),
    .match (match),
    .odd   (odd)
  );

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    load    = 1'b0;
    err_d   = 1'b0;
    wrap_d  = 1'b0;
    if (EN) begin
      case (state_q)
        ST_SYNC: begin
          if (!odd) begin
            load    = 1'b1;
            step_d  = 4'd0;
            state_d = ST_ACQ;
          end
        end
        ST_ACQ: begin
          if (match) begin
            load   = 1'b1;
            step_d = step_q + 4'd1;
            if (step_q + 4'd1 == LOCK_CNT4) state_d = ST_LOCKED;
          end else if (!odd) begin
            // a fresh even value restarts acquisition from itself
            load   = 1'b1;
            step_d = 4'd0;
          end else begin
            step_d  = 4'd0;
            state_d = ST_SYNC;
          end
        end
        ST_LOCKED: begin
          if (match) begin
            load   = 1'b1;
            wrap_d = (p == WRAP_PT) && (s == 4'd0);
          end else begin
            err_d  = 1'b1;
            step_d = 4'd0;
`ifdef EVEN_CHK_STICKY_ERR_EN
            state_d = ST_FAIL;
`else
            if (!odd) begin
              load    = 1'b1;
              state_d = ST_ACQ;
            end else begin
              state_d = ST_SYNC;
            end
`endif
          end
        end
`ifdef EVEN_CHK_STICKY_ERR_EN
        ST_FAIL: state_d = ST_FAIL;
`endif
        default: state_d = ST_SYNC;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_SYNC;
      step_q  <= 4'd0;
      LOCK    <= 1'b0;
      ERR     <= 1'b0;
      WRAP    <= 1'b0;
      ERR_CNT <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      LOCK    <= (state_d == ST_LOCKED);
      ERR     <= err_d;
      WRAP    <= wrap_d;
      if (err_d && (ERR_CNT != '1)) ERR_CNT <= ERR_CNT + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_even_count_checker.sv
// Directed table-driven bench for even_count_checker plus saturation and reset sequences.
module tb_even_count_checker;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       EN  = 1'b0;
  logic       A = 1'b0, B = 1'b0, C = 1'b0, D = 1'b0;
  logic       LOCK, ERR, WRAP;
  logic [7:0] ERR_CNT;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  even_count_checker #(.LOCK_CNT(2), .ERR_CNT_W(8)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .A(A), .B(B), .C(C), .D(D),
    .LOCK(LOCK), .ERR(ERR), .WRAP(WRAP), .ERR_CNT(ERR_CNT)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] s;
    logic       lock;
    logic       err;
    logic       wrap;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic en, logic [3:0] s, logic l, logic er, logic w, logic [7:0] c);
    vec_t v;
    v.rst = r; v.en = en; v.s = s; v.lock = l; v.err = er; v.wrap = w; v.cnt = c;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0d: got %0d expected %0d", name, idx, got, exp);
    end
  endtask

  // drive on the falling edge, sample 1ns after the rising edge
  task automatic step(input logic r, input logic en, input logic [3:0] s);
    @(negedge CLK);
    RST = r; EN = en; {A, B, C, D} = s;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_all(input string name, input int idx, input logic l, input logic er,
                         input logic w, input logic [7:0] c);
    chk({name, ".lock"}, idx, {7'd0, LOCK}, {7'd0, l});
    chk({name, ".err"},  idx, {7'd0, ERR},  {7'd0, er});
    chk({name, ".wrap"}, idx, {7'd0, WRAP}, {7'd0, w});
    chk({name, ".cnt"},  idx, ERR_CNT, c);
    chk({name, ".excl"}, idx, {7'd0, ERR & WRAP}, 8'd0);
  endtask

  initial begin
    int v;
    int npulse;
    // reset state is forced regardless of EN
    tbl.push_back(mk(1, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1,  3, 0, 0, 0, 0));  // odd in SYNC: silent
    tbl.push_back(mk(0, 1,  0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1,  2, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1,  4, 1, 0, 0, 0));  // lock one cycle after 4
    tbl.push_back(mk(0, 1,  6, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1,  8, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 10, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 12, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 14, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1,  0, 1, 0, 1, 0));  // wrap 14 -> 0
    tbl.push_back(mk(0, 1,  2, 1, 0, 0, 0));
`ifndef EVEN_CHK_STICKY_ERR_EN
    tbl.push_back(mk(0, 1,  2, 0, 1, 0, 1));  // repeat -> error, ACQ from 2
    tbl.push_back(mk(0, 1,  4, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1,  6, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0,  9, 1, 0, 0, 1));  // EN=0 holds
    tbl.push_back(mk(0, 1,  8, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 11, 0, 1, 0, 2));  // odd in LOCKED -> SYNC
    tbl.push_back(mk(0, 1,  5, 0, 0, 0, 2));
    tbl.push_back(mk(0, 1,  4, 0, 0, 0, 2));
    tbl.push_back(mk(0, 1,  8, 0, 0, 0, 2));  // ACQ mismatch restarts, no ERR
    tbl.push_back(mk(0, 1, 10, 0, 0, 0, 2));
    tbl.push_back(mk(0, 1, 12, 1, 0, 0, 2));
    tbl.push_back(mk(1, 1,  7, 0, 0, 0, 0));  // reset while locked
    tbl.push_back(mk(0, 1,  0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1,  2, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1,  4, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1,  6, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 10, 0, 1, 0, 1));  // skip 8 -> error
    tbl.push_back(mk(0, 1, 12, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 14, 1, 0, 0, 1));  // relock after 14
    tbl.push_back(mk(0, 1,  0, 1, 0, 1, 1));
    tbl.push_back(mk(0, 1,  2, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 13, 1, 0, 0, 1));  // gap between 2 and 4
    tbl.push_back(mk(0, 1,  4, 1, 0, 0, 1));
`else
    tbl.push_back(mk(1, 1,  0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1,  0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1,  2, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1,  4, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1,  6, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1,  7, 0, 1, 0, 1));  // error -> FAIL
    tbl.push_back(mk(0, 1,  8, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 10, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1,  3, 0, 0, 0, 1));  // no further errors in FAIL
    tbl.push_back(mk(1, 1,  0, 0, 0, 0, 0));
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].en, tbl[i].s);
      chk_all("tbl", i, tbl[i].lock, tbl[i].err, tbl[i].wrap, tbl[i].cnt);
    end

`ifndef EVEN_CHK_STICKY_ERR_EN
    // saturation: lock, then repeat (error), +2, +4 relocks; 300 times
    step(1, 1, 0);
    step(0, 1, 0);
    step(0, 1, 2);
    step(0, 1, 4);
    chk_all("sat_lock", 0, 1, 0, 0, 0);
    v = 4;
    npulse = 0;
    for (int k = 0; k < 300; k++) begin
      step(0, 1, 4'(v));
      if (ERR === 1'b1) npulse++;
      if (k < 3) chk_all("sat_err", k, 0, 1, 0, 8'(k + 1));
      step(0, 1, 4'(v + 2));
      step(0, 1, 4'(v + 4));
      v = (v + 4) % 16;
    end
    chk("sat_pulses", 0, 8'(npulse > 255 ? 255 : npulse), 8'd255);
    chk("sat_pulses_hi", 0, {7'd0, npulse == 300}, 8'd1);
    chk_all("sat_end", 0, 1, 0, 0, 255);
    step(0, 1, 4'(v));
    chk_all("sat_more", 0, 0, 1, 0, 255);
    step(1, 1, 4'(v + 2));
    chk_all("sat_rst", 0, 0, 0, 0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
